// File: rtl/cart_upload_tx.sv
// Cartridge upload producer: buffers the HPS ioctl stream and
// re-emits it as paced upload strobes, padding the cart window.
module cart_upload_tx #(
  parameter int          FIFO_AW    = 2,
  parameter int          CART_BYTES = 32768,
  parameter int          PACE       = 2,
  parameter logic [7:0]  FILL_BYTE  = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        upload,
  output logic [7:0]  upload_index,
  output logic [24:0] upload_addr,
  output logic [7:0]  upload_data,
  output logic        busy,
  output logic [15:0] cart_len,
  output logic        done,
  output logic        overrun
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [24:0]      CART_W = 25'(CART_BYTES);
  localparam logic [15:0]      CART_L = 16'(CART_BYTES);
  localparam logic [15:0]      LAST   = 16'(CART_BYTES - 1);
  localparam logic [3:0]       PACE_R = 4'(PACE - 1);
  localparam logic [FIFO_AW:0] FULL_C = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0] HIGH_C = (FIFO_AW + 1)'(DEPTH - 1);
  localparam logic [FIFO_AW:0] ONE_C  = (FIFO_AW + 1)'(1);

  typedef enum logic [1:0] {IDLE, RECV, FILL, DONE} state_t;

  state_t state, state_nx;

  logic [22:0]        mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [3:0]         pace;
  logic               armed;
  logic [15:0]        fill_addr;

  logic        in_win, full, empty, wr_ok, push, push_mem;
  logic        strobe_rx, strobe_fill, fifo_pop, bypass, start;
  logic [24:0] addr_p1;
  logic [22:0] head;

  assign in_win      = ioctl_addr < CART_W;
  assign full        = count == FULL_C;
  assign empty       = count == '0;
  assign wr_ok       = state == RECV && ioctl_wr && in_win;
  assign push        = wr_ok && !full;
  assign strobe_rx   = pace == '0 && (!empty || push);
  assign fifo_pop    = strobe_rx && !empty;
  // an empty FIFO hands the incoming byte straight to the output
  assign bypass      = strobe_rx && empty;
  assign push_mem    = push && !bypass;
  assign head        = empty ? {ioctl_addr[14:0], ioctl_dout}
                             : mem[rd_ptr];
  assign strobe_fill = state == FILL && pace == '0;
  assign start       = state == IDLE && ioctl_download && armed;
  assign addr_p1     = ioctl_addr + 25'd1;

  assign ioctl_wait = count >= HIGH_C || state == FILL ||
                      state == DONE;
  assign busy       = state != IDLE;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (start) state_nx = RECV;
      RECV: begin
        if (!ioctl_download && empty && !push) begin
          if (upload_index == 8'd1 && cart_len < CART_L)
            state_nx = FILL;
          else
            state_nx = DONE;
        end
      end
      FILL: if (strobe_fill && fill_addr == LAST) state_nx = DONE;
      DONE: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_mem) mem[wr_ptr] <= {ioctl_addr[14:0], ioctl_dout};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      armed        <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      pace         <= '0;
      fill_addr    <= '0;
      upload       <= 1'b0;
      upload_index <= '0;
      upload_addr  <= '0;
      upload_data  <= '0;
      cart_len     <= '0;
      done         <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state <= state_nx;
      done  <= state_nx == DONE && state != DONE;

      if (!ioctl_download) armed <= 1'b1;
      else if (start)      armed <= 1'b0;

      if (start) begin
        upload_index <= ioctl_index;
        cart_len     <= '0;
      end else if (wr_ok && addr_p1 > {9'd0, cart_len}) begin
        cart_len <= 16'(addr_p1);
      end

      if (wr_ok && full) overrun <= 1'b1;

      if (push_mem) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_mem, fifo_pop})
        2'b10:   count <= count + ONE_C;
        2'b01:   count <= count - ONE_C;
        default: count <= count;
      endcase

      upload <= strobe_rx || strobe_fill;
      if (strobe_rx) begin
        upload_addr <= {10'd0, head[22:8]};
        upload_data <= head[7:0];
      end else if (strobe_fill) begin
        upload_addr <= 25'(fill_addr);
        upload_data <= FILL_BYTE;
      end

      if (strobe_rx || strobe_fill) pace <= PACE_R;
      else if (pace != '0)          pace <= pace - 4'd1;

      if (state == RECV && state_nx == FILL) fill_addr <= cart_len;
      else if (strobe_fill)                  fill_addr <= fill_addr + 16'd1;
    end
  end

endmodule

// File: tb/tb_cart_upload_tx.sv
// Scoreboard bench for cart_upload_tx: randomized downloads checked
// against a queue-based reference of the expected upload stream.
module tb_cart_upload_tx;

  localparam int AW   = 2;
  localparam int D    = 4;
  localparam int CART = 256;
  localparam int P    = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = '0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [7:0]  ioctl_dout = '0;
  logic        ioctl_wait, upload, busy, done, overrun;
  logic [7:0]  upload_index, upload_data;
  logic [24:0] upload_addr;
  logic [15:0] cart_len;

  cart_upload_tx #(
    .FIFO_AW(AW), .CART_BYTES(CART), .PACE(P), .FILL_BYTE(8'hFF)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .upload(upload), .upload_index(upload_index),
    .upload_addr(upload_addr), .upload_data(upload_data),
    .busy(busy), .cart_len(cart_len), .done(done),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [24:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t       exp_q[$];
  int         aq[$];
  int         dq[$];
  int         n_vec = 0;
  int         n_err = 0;
  int         done_cnt = 0;
  int         cyc = 0;
  int         last_up = -100;
  int         exp_len = 0;
  logic [7:0] cur_idx = '0;
  logic       ovr_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // monitor: every strobe must match the head of the expected stream
  always @(negedge clk) begin
    if (reset_n) begin
      if (upload) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL upload_extra: got addr %0h want none",
                   upload_addr);
        end else begin
          ent_t e;
          e = exp_q.pop_front();
          chk("upload_addr", upload_addr, e.a);
          chk("upload_data", upload_data, e.d);
          chk("upload_index", upload_index, cur_idx);
          chk("pace_gap", (cyc - last_up) >= P, 1);
        end
        last_up = cyc;
      end
      if (done) begin
        done_cnt++;
        chk("done_q_empty", exp_q.size(), 0);
      end
    end
  end

  task automatic run_xfer(input logic [7:0] idx, input bit gaps,
                          input bit lat);
    int guard;
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    cur_idx        = idx;
    exp_len        = 0;
    tick();
    for (int i = 0; i < aq.size(); i++) begin
      guard = 0;
      while (ioctl_wait && guard < 100) begin
        tick();
        guard++;
      end
      if (guard >= 100) begin
        n_vec++;
        n_err++;
        $display("FAIL wait_timeout: got wait stuck want release");
      end
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(aq[i]);
      ioctl_dout = 8'(dq[i]);
      if (aq[i] < CART) begin
        exp_q.push_back({25'(aq[i]), 8'(dq[i])});
        if (aq[i] + 1 > exp_len) exp_len = aq[i] + 1;
      end
      tick();
      ioctl_wr = 1'b0;
      if (lat && i == 0) chk("latency", upload, 1);
      if (gaps) repeat ($urandom_range(0, 2)) tick();
    end
    if (idx == 8'd1 && exp_len < CART)
      for (int a = exp_len; a < CART; a++)
        exp_q.push_back({25'(a), 8'hFF});
    ioctl_download = 1'b0;
    aq.delete();
    dq.delete();
  endtask

  task automatic finish_xfer(input int d0, input logic [7:0] idx);
    int g;
    g = 0;
    while (done_cnt == d0 && g < 3000) begin
      tick();
      g++;
    end
    repeat (3) tick();
    chk("done_pulses", done_cnt - d0, 1);
    chk("exp_drained", exp_q.size(), 0);
    chk("cart_len", cart_len, exp_len);
    chk("busy_idle", busy, 0);
    chk("overrun", overrun, ovr_exp);
    chk("index_latch", upload_index, idx);
    exp_q.delete();
  endtask

  task automatic burst(input int n);
    int acc, cnt, d0;
    acc = 0;
    d0  = done_cnt;
    ioctl_index    = 8'd3;
    ioctl_download = 1'b1;
    cur_idx        = 8'd3;
    tick();
    // strobes fire at k = 0, P, 2P ... while the backlog lasts
    for (int k = 0; k < n; k++) begin
      cnt = acc - ((k == 0) ? 0 : (k - 1) / P + 1);
      chk("wait_level", ioctl_wait, cnt >= D - 1);
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(k);
      ioctl_dout = 8'($urandom);
      if (cnt < D) begin
        exp_q.push_back({25'(k), ioctl_dout});
        acc++;
      end else begin
        ovr_exp = 1'b1;
      end
      tick();
    end
    ioctl_wr       = 1'b0;
    ioctl_download = 1'b0;
    exp_len        = n;
    finish_xfer(d0, 8'd3);
  endtask

  initial begin
    int d0, g, n;
    logic [7:0] idx;

    ioctl_download = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1;
    chk("rst_upload", upload, 0);
    chk("rst_index", upload_index, 0);
    chk("rst_addr", upload_addr, 0);
    chk("rst_data", upload_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cart_len", cart_len, 0);
    chk("rst_done", done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_wait", ioctl_wait, 0);

    // download high at reset release must be ignored
    for (int i = 0; i < 6; i++) begin
      ioctl_wr   = 1'b1;
      ioctl_addr = 25'(i);
      ioctl_dout = 8'($urandom);
      tick();
      ioctl_wr = 1'b0;
      tick();
    end
    chk("unarmed_busy", busy, 0);
    chk("unarmed_len", cart_len, 0);
    ioctl_download = 1'b0;
    repeat (2) tick();

    d0 = done_cnt;
    aq = '{0, 1, 2, 3};
    dq = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_xfer(8'd1, 1'b0, 1'b1);
    finish_xfer(d0, 8'd1);

    d0 = done_cnt;
    for (int i = 0; i < CART; i++) begin
      aq.push_back(i);
      dq.push_back($urandom_range(0, 255));
    end
    run_xfer(8'd1, 1'b1, 1'b0);
    finish_xfer(d0, 8'd1);

    d0 = done_cnt;
    for (int i = 0; i < 16; i++) begin
      aq.push_back(32'h8000 + i);
      dq.push_back($urandom_range(0, 255));
    end
    run_xfer(8'd2, 1'b0, 1'b0);
    finish_xfer(d0, 8'd2);

    for (int t = 0; t < 4; t++) begin
      d0  = done_cnt;
      idx = ($urandom_range(0, 1) == 1) ? 8'd1 : 8'd5;
      n   = $urandom_range(1, 20);
      for (int i = 0; i < n; i++) begin
        aq.push_back($urandom_range(0, CART + 15));
        dq.push_back($urandom_range(0, 255));
      end
      run_xfer(idx, 1'b1, 1'b0);
      finish_xfer(d0, idx);
    end

    d0 = done_cnt;
    run_xfer(8'd1, 1'b0, 1'b0);
    finish_xfer(d0, 8'd1);

    burst(12);

    // reset in the middle of the fill phase
    aq = '{0, 1};
    dq = '{8'hA5, 8'h5A};
    run_xfer(8'd1, 1'b0, 1'b0);
    g = 0;
    while (exp_q.size() > CART - 12 && g < 2000) begin
      tick();
      g++;
    end
    chk("fill_started", exp_q.size() <= CART - 12, 1);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_upload", upload, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", upload_addr, 0);
    chk("arst_index", upload_index, 0);
    chk("arst_len", cart_len, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_wait", ioctl_wait, 0);
    exp_q.delete();
    last_up = -100;
    ovr_exp = 1'b0;
    d0 = done_cnt;
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (20) tick();
    chk("no_done_after_reset", done_cnt - d0, 0);
    chk("idle_after_reset", busy, 0);

    d0 = done_cnt;
    for (int i = 0; i < 6; i++) begin
      aq.push_back(40 + i);
      dq.push_back($urandom_range(0, 255));
    end
    run_xfer(8'd4, 1'b0, 1'b1);
    finish_xfer(d0, 8'd4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
